// File: rtl/rgb_pwm_demod_if.sv
// Signal bundle between the RGB PWM demodulator and its driver/consumer.
// The master side is the demodulator, which sources the recovered levels.
interface rgb_pwm_demod_if #(
  parameter int PWM_RESOLUTION = 8
);
  logic                      en;
  logic                      pwm_r_n;
  logic                      pwm_g_n;
  logic                      pwm_b_n;
  logic [PWM_RESOLUTION-1:0] level_r;
  logic [PWM_RESOLUTION-1:0] level_g;
  logic [PWM_RESOLUTION-1:0] level_b;
  logic                      level_valid;
  logic                      level_ready;
  logic                      locked;
  logic                      overrun;

  modport master (
    input  en, pwm_r_n, pwm_g_n, pwm_b_n, level_ready,
    output level_r, level_g, level_b, level_valid, locked, overrun
  );

  modport slave (
    output en, pwm_r_n, pwm_g_n, pwm_b_n, level_ready,
    input  level_r, level_g, level_b, level_valid, locked, overrun
  );
endinterface

// File: rtl/rgb_pwm_demod.sv
// Recovers RGB levels from three active-low PWM lines by counting on-cycles
// over a free-running window exactly one PWM period long.
module rgb_pwm_demod #(
  parameter int PWM_RESOLUTION = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_TOL       = 1
) (
  input  logic            clk,
  input  logic            rst,
  rgb_pwm_demod_if.master bus
);
  localparam int LW = PWM_RESOLUTION;
  localparam int AW = PWM_RESOLUTION + 1;

  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_MEASURE} state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_run;
  logic   w_measure;

  logic [SYNC_STAGES-1:0] r_sync_r;
  logic [SYNC_STAGES-1:0] r_sync_g;
  logic [SYNC_STAGES-1:0] r_sync_b;
  logic [2:0]             w_on;

  logic [LW-1:0] r_win_cnt;
  logic          w_win_last;
  logic          w_wend;
  logic [AW-1:0] r_acc_p0 [0:2];
  logic [AW-1:0] w_cnt    [0:2];
  logic [LW-1:0] w_lvl    [0:2];
  logic          w_lock_ok;

  logic [LW-1:0] r_level_p1 [0:2];
  logic [LW-1:0] r_prev_p1  [0:2];
  logic          r_prev_vld_p1;
  logic          r_valid_p1;
  logic          r_locked_p1;
  logic          r_overrun_p1;

  // An empty window means level 0; otherwise L+1 on-cycles encode level L.
  function automatic logic [LW-1:0] cnt_to_level(input logic [AW-1:0] cnt);
    logic [AW-1:0] dec;
    dec = cnt - AW'(1);
    return (cnt == '0) ? '0 : dec[LW-1:0];
  endfunction

  function automatic logic within_tol(input logic [LW-1:0] a, input logic [LW-1:0] b);
    logic signed [AW-1:0] diff;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    if (diff < 0) diff = -diff;
    return diff <= $signed(AW'(LOCK_TOL));
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_r <= '0;
      r_sync_g <= '0;
      r_sync_b <= '0;
    end else begin
      r_sync_r <= {r_sync_r[SYNC_STAGES-2:0], bus.pwm_r_n};
      r_sync_g <= {r_sync_g[SYNC_STAGES-2:0], bus.pwm_g_n};
      r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], bus.pwm_b_n};
    end
  end

  assign w_on = ~{r_sync_b[SYNC_STAGES-1], r_sync_g[SYNC_STAGES-1], r_sync_r[SYNC_STAGES-1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!bus.en) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    w_state_nxt = S_ALIGN;
        S_ALIGN:   if (w_win_last) w_state_nxt = S_MEASURE;
        S_MEASURE: w_state_nxt = S_MEASURE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_run     = 1'b0;
    w_measure = 1'b0;
    case (r_state)
      S_ALIGN:   w_run = bus.en;
      S_MEASURE: begin
        w_run     = bus.en;
        w_measure = bus.en;
      end
      default: ;
    endcase
  end

  assign w_win_last = (r_win_cnt == '1);
  assign w_wend     = w_measure && w_win_last;

  // Stage p0: window counter and per-channel on-cycle accumulators
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_cnt <= '0;
      for (int i = 0; i < 3; i++) r_acc_p0[i] <= '0;
    end else begin
      r_win_cnt <= w_run ? r_win_cnt + LW'(1) : '0;
      for (int i = 0; i < 3; i++) begin
        if (!w_measure || w_win_last) r_acc_p0[i] <= '0;
        else                          r_acc_p0[i] <= r_acc_p0[i] + AW'(w_on[i]);
      end
    end
  end

  // The last window cycle is folded in combinationally so the accumulator restarts at once.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_cnt[i] = r_acc_p0[i] + AW'(w_on[i]);
      w_lvl[i] = cnt_to_level(w_cnt[i]);
    end
    w_lock_ok = within_tol(w_lvl[0], r_prev_p1[0]) &&
                within_tol(w_lvl[1], r_prev_p1[1]) &&
                within_tol(w_lvl[2], r_prev_p1[2]);
  end

  // Stage p1: result register, handshake, lock and overrun tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        r_level_p1[i] <= '0;
        r_prev_p1[i]  <= '0;
      end
      r_prev_vld_p1 <= 1'b0;
      r_valid_p1    <= 1'b0;
      r_locked_p1   <= 1'b0;
      r_overrun_p1  <= 1'b0;
    end else if (!bus.en) begin
      r_prev_vld_p1 <= 1'b0;
      r_valid_p1    <= 1'b0;
      r_locked_p1   <= 1'b0;
      r_overrun_p1  <= 1'b0;
    end else if (w_wend) begin
      for (int i = 0; i < 3; i++) begin
        r_level_p1[i] <= w_lvl[i];
        r_prev_p1[i]  <= w_lvl[i];
      end
      if (r_valid_p1 && !bus.level_ready) r_overrun_p1 <= 1'b1;
      r_valid_p1    <= 1'b1;
      r_prev_vld_p1 <= 1'b1;
      r_locked_p1   <= r_prev_vld_p1 && w_lock_ok;
    end else if (r_valid_p1 && bus.level_ready) begin
      r_valid_p1 <= 1'b0;
    end
  end

  assign bus.level_r     = r_level_p1[0];
  assign bus.level_g     = r_level_p1[1];
  assign bus.level_b     = r_level_p1[2];
  assign bus.level_valid = r_valid_p1;
  assign bus.locked      = r_locked_p1;
  assign bus.overrun     = r_overrun_p1;
endmodule

// File: tb/tb_rgb_pwm_demod.sv
// Scoreboard bench for rgb_pwm_demod: a reference PWM source drives the lines,
// expected levels are queued per window and checked on each output transfer.
`timescale 1ns/1ps
module tb_rgb_pwm_demod;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   phase = 0;
  int   pidx;
  int   lvl_r = -1;
  int   lvl_g = -1;
  int   lvl_b = -1;
  int   n_checks = 0;
  int   n_err = 0;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       lk;
  } exp_t;
  exp_t sb[$];

  rgb_pwm_demod_if #(.PWM_RESOLUTION(8)) bus ();

  rgb_pwm_demod #(.PWM_RESOLUTION(8), .SYNC_STAGES(2), .LOCK_TOL(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference transmitter: line is on (low) while its counter <= level.
  // Level -1 keeps the line off, 256 keeps it on.
  always_comb begin
    pidx = (cyc + phase) & 255;
    bus.pwm_r_n = !(pidx <= lvl_r);
    bus.pwm_g_n = !(pidx <= lvl_g);
    bus.pwm_b_n = !(pidx <= lvl_b);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input logic lk);
    exp_t e;
    e.r = r; e.g = g; e.b = b; e.lk = lk;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(output int c0);
    c0 = cyc;
    bus.en = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level_r"}, bus.level_r, 0);
    chk({tag, "_level_g"}, bus.level_g, 0);
    chk({tag, "_level_b"}, bus.level_b, 0);
    chk({tag, "_valid"}, bus.level_valid, 0);
    chk({tag, "_locked"}, bus.locked, 0);
    chk({tag, "_overrun"}, bus.overrun, 0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.level_valid === 1'b1 && bus.level_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_unexpected: got r=0x%0h g=0x%0h b=0x%0h expected no transfer (cycle %0d)",
                   bus.level_r, bus.level_g, bus.level_b, cyc);
        end else begin
          e = sb.pop_front();
          chk("sb_level_r", bus.level_r, e.r);
          chk("sb_level_g", bus.level_g, e.g);
          chk("sb_level_b", bus.level_b, e.b);
          chk("sb_locked", bus.locked, e.lk);
        end
      end
    end
  endtask

  initial begin
    int c0;
    int offs[4];
    offs[0] = 0; offs[1] = 1; offs[2] = 128; offs[3] = 255;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.level_ready = 1'b1;
    fork
      monitor();
      begin
        wait_to(3);
        chk_all_zero("reset");
        rst = 1'b0;
        wait_to(6);

        // Steady levels, then en dropped at win_cnt=100
        lvl_r = 'h80; lvl_g = 'h00; lvl_b = 'hFF;
        start(c0);
        push(8'h80, 8'h00, 8'hFF, 1'b0);
        push(8'h80, 8'h00, 8'hFF, 1'b1);
        push(8'h80, 8'h00, 8'hFF, 1'b1);
        wait_to(c0 + 512);  chk("valid_before_first", bus.level_valid, 0);
        wait_to(c0 + 513);  chk("valid_first", bus.level_valid, 1);
        wait_to(c0 + 770);  chk("locked_after_w2", bus.locked, 1);
        wait_to(c0 + 1125); chk("locked_before_drop", bus.locked, 1);
        bus.en = 1'b0;
        wait_to(c0 + 1127);
        chk("drop_valid", bus.level_valid, 0);
        chk("drop_locked", bus.locked, 0);
        chk("drop_hold_r", bus.level_r, 'h80);
        chk("drop_hold_g", bus.level_g, 'h00);
        chk("drop_hold_b", bus.level_b, 'hFF);
        wait_to(cyc + 4);

        // Extremes: constantly off, constantly on
        lvl_r = -1; lvl_g = 256; lvl_b = 1;
        start(c0);
        push(8'h00, 8'hFF, 8'h01, 1'b0);
        push(8'h00, 8'hFF, 8'h01, 1'b1);
        wait_to(c0 + 767);
        lvl_r = 256;
        push(8'hFF, 8'hFF, 8'h01, 1'b0);
        push(8'hFF, 8'hFF, 8'h01, 1'b1);
        wait_to(c0 + 1282);
        bus.en = 1'b0;
        wait_to(cyc + 4);

        // Phase sweep
        lvl_r = 'h40; lvl_g = 'h20; lvl_b = 'hC0;
        foreach (offs[k]) begin
          phase = offs[k] - cyc;
          start(c0);
          push(8'h40, 8'h20, 8'hC0, 1'b0);
          wait_to(c0 + 515);
          bus.en = 1'b0;
          wait_to(cyc + 4);
        end
        phase = 0;

        // Backpressure over three windows
        lvl_r = 'h10; lvl_g = 'h20; lvl_b = 'h30;
        bus.level_ready = 1'b0;
        start(c0);
        wait_to(c0 + 514);
        chk("bp_valid_w1", bus.level_valid, 1);
        chk("bp_overrun_w1", bus.overrun, 0);
        wait_to(c0 + 600);  chk("bp_stable_r", bus.level_r, 'h10);
        wait_to(c0 + 767);  lvl_r = 'h11;
        wait_to(c0 + 770);
        chk("bp_overrun_w2", bus.overrun, 1);
        chk("bp_valid_w2", bus.level_valid, 1);
        wait_to(c0 + 1026);
        chk("bp_latest_r", bus.level_r, 'h11);
        chk("bp_valid_w3", bus.level_valid, 1);
        push(8'h11, 8'h20, 8'h30, 1'b1);
        wait_to(c0 + 1100);
        bus.level_ready = 1'b1;
        wait_to(c0 + 1103);
        chk("bp_valid_cleared", bus.level_valid, 0);
        chk("bp_overrun_sticky", bus.overrun, 1);
        bus.en = 1'b0;
        wait_to(c0 + 1105);
        chk("bp_overrun_idle_clear", bus.overrun, 0);
        wait_to(cyc + 4);

        // Lock step, then asynchronous reset mid-MEASURE
        lvl_r = 'h10; lvl_g = 'h55; lvl_b = 'h55;
        start(c0);
        push(8'h10, 8'h55, 8'h55, 1'b0);
        push(8'h10, 8'h55, 8'h55, 1'b1);
        wait_to(c0 + 767);  lvl_r = 'h11;
        push(8'h11, 8'h55, 8'h55, 1'b1);
        wait_to(c0 + 1023); lvl_r = 'h20;
        push(8'h20, 8'h55, 8'h55, 1'b0);
        push(8'h20, 8'h55, 8'h55, 1'b1);
        wait_to(c0 + 1026); chk("lock_small_step", bus.locked, 1);
        wait_to(c0 + 1282); chk("lock_big_step", bus.locked, 0);
        wait_to(c0 + 1538); chk("lock_regained", bus.locked, 1);
        wait_to(c0 + 1600);
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        wait_to(c0 + 1602);
        rst = 1'b0;
        c0 = cyc;
        push(8'h20, 8'h55, 8'h55, 1'b0);
        wait_to(c0 + 512); chk("realign_no_early", bus.level_valid, 0);
        wait_to(c0 + 514); chk("realign_locked", bus.locked, 0);
        bus.en = 1'b0;
        wait_to(cyc + 10);
      end
    join_any
    disable fork;
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
